// File: rtl/framed_packet_serializer_pkg.sv
// Shared types and helpers for the framed packet serializer.
//   serializer_state_t : frame phase
//   bit_index_width()  : counter width needed to index n positions (min 1)
package framed_packet_serializer_pkg;

  localparam int       DEF_PACKET_SIZE    = 192;
  localparam int       DEF_PREAMBLE_WIDTH = 8;
  localparam bit [7:0] DEF_PREAMBLE       = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_GAP
  } serializer_state_t;

  function automatic int bit_index_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/framed_packet_serializer_if.sv
// Load handshake bundle for the framed packet serializer.
//   load_packet/load_repeat/load_valid : master -> slave
//   load_ready                         : slave  -> master
interface framed_packet_serializer_if #(
  parameter int PACKET_SIZE  = 192,
  parameter int REPEAT_WIDTH = 8
);
  logic [PACKET_SIZE-1:0]  load_packet;
  logic [REPEAT_WIDTH-1:0] load_repeat;
  logic                    load_valid;
  logic                    load_ready;

  modport master (output load_packet, load_repeat, load_valid, input load_ready);
  modport slave  (input load_packet, load_repeat, load_valid, output load_ready);
endinterface

// File: rtl/framed_packet_serializer_bit_counter.sv
// Loadable down-counter with terminal-count flag. Load wins over decrement;
// decrement at zero holds (no wrap).
//   clock, reset_n : clock / async active-low reset
//   load, load_val : load a new start value
//   dec            : step down by one
//   count, tc      : current value, count==0
module framed_packet_serializer_bit_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       count <= '0;
    else if (load)      count <= load_val;
    else if (dec && !tc) count <= count - W'(1);
  end

endmodule

// File: rtl/framed_packet_serializer.sv
// Framed packet serializer: preamble (MSB-first), payload (MSB- or LSB-first),
// optional repeats separated by idle zero gap bits. One bit per `next` strobe.
//   clock, reset_n       : clock / async active-low reset
//   ld                   : load handshake (packet, repeat count, valid/ready)
//   abort                : synchronous return to IDLE, highest priority
//   next                 : modulator consumed the current bit
//   bit_out, bit_valid   : current serial bit and its qualifier
//   frame_start          : pulse when the first preamble bit is presented
//   frame_done           : pulse after the last payload bit of a frame is consumed
//   busy                 : not IDLE
module framed_packet_serializer
  import framed_packet_serializer_pkg::*;
#(
  parameter int                      PACKET_SIZE    = DEF_PACKET_SIZE,
  parameter int                      PREAMBLE_WIDTH = DEF_PREAMBLE_WIDTH,
  parameter logic [PREAMBLE_WIDTH-1:0] PREAMBLE     = DEF_PREAMBLE,
  parameter int                      GAP_BITS       = 4,
  parameter int                      LSB_FIRST      = 0,
  parameter int                      REPEAT_WIDTH   = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  framed_packet_serializer_if.slave   ld,
  input  logic                        abort,
  input  logic                        next,
  output logic                        bit_out,
  output logic                        bit_valid,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic                        busy
);

  // One shared index counter covers preamble, payload and gap phases.
  localparam int IDX_MAX = (PACKET_SIZE > PREAMBLE_WIDTH)
                           ? ((PACKET_SIZE > GAP_BITS) ? PACKET_SIZE : GAP_BITS)
                           : ((PREAMBLE_WIDTH > GAP_BITS) ? PREAMBLE_WIDTH : GAP_BITS);
  localparam int CNT_W = bit_index_width(IDX_MAX);
  localparam int PIX_W = bit_index_width(PACKET_SIZE);
  localparam int RIX_W = bit_index_width(PREAMBLE_WIDTH);

  localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PREAMBLE_WIDTH - 1);
  localparam logic [CNT_W-1:0] PAY_LD = CNT_W'(PACKET_SIZE - 1);
  localparam logic [CNT_W-1:0] GAP_LD = (GAP_BITS > 0) ? CNT_W'(GAP_BITS - 1) : '0;

  serializer_state_t       state, state_nxt;
  logic [PACKET_SIZE-1:0]  pkt_q;
  logic [REPEAT_WIDTH-1:0] rep_q;
  logic [CNT_W-1:0]        cnt, cnt_ld_val;
  logic                    cnt_tc, cnt_ld, cnt_dec;
  logic                    take, rep_dec, fs_nxt, fd_nxt;
  logic [PIX_W-1:0]        pay_idx;

  framed_packet_serializer_bit_counter #(.W(CNT_W)) u_idx (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_ld),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  assign ld.load_ready = (state == ST_IDLE) && !abort;
  assign busy          = (state != ST_IDLE);
  assign bit_valid     = busy;

  // Counter runs down from the last index; MSB-first payload indexes by the
  // count directly, LSB-first mirrors it.
  assign pay_idx = (LSB_FIRST != 0) ? (PIX_W'(PACKET_SIZE - 1) - cnt[PIX_W-1:0])
                                    : cnt[PIX_W-1:0];

  always_comb begin
    bit_out = 1'b0;
    case (state)
      ST_PREAMBLE: bit_out = PREAMBLE[cnt[RIX_W-1:0]];
      ST_PAYLOAD:  bit_out = pkt_q[pay_idx];
      default:     bit_out = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    cnt_dec    = 1'b0;
    take       = 1'b0;
    rep_dec    = 1'b0;
    fs_nxt     = 1'b0;
    fd_nxt     = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (ld.load_valid) begin
          take       = 1'b1;
          state_nxt  = ST_PREAMBLE;
          cnt_ld     = 1'b1;
          cnt_ld_val = PRE_LD;
          fs_nxt     = 1'b1;
        end
        ST_PREAMBLE: if (next) begin
          if (cnt_tc) begin
            state_nxt  = ST_PAYLOAD;
            cnt_ld     = 1'b1;
            cnt_ld_val = PAY_LD;
          end else cnt_dec = 1'b1;
        end
        ST_PAYLOAD: if (next) begin
          if (cnt_tc) begin
            fd_nxt = 1'b1;
            if (rep_q == '0) begin
              state_nxt = ST_IDLE;
            end else begin
              rep_dec = 1'b1;
              cnt_ld  = 1'b1;
              if (GAP_BITS > 0) begin
                state_nxt  = ST_GAP;
                cnt_ld_val = GAP_LD;
              end else begin
                state_nxt  = ST_PREAMBLE;
                cnt_ld_val = PRE_LD;
                fs_nxt     = 1'b1;
              end
            end
          end else cnt_dec = 1'b1;
        end
        ST_GAP: if (next) begin
          if (cnt_tc) begin
            state_nxt  = ST_PREAMBLE;
            cnt_ld     = 1'b1;
            cnt_ld_val = PRE_LD;
            fs_nxt     = 1'b1;
          end else cnt_dec = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pkt_q       <= '0;
      rep_q       <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_start <= fs_nxt;
      frame_done  <= fd_nxt;
      if (take) begin
        pkt_q <= ld.load_packet;
        rep_q <= ld.load_repeat;
      end else if (rep_dec) begin
        rep_q <= rep_q - REPEAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_framed_packet_serializer.sv
module tb_framed_packet_serializer;

  localparam int       N   = 16;
  localparam int       PW  = 8;
  localparam bit [7:0] PRE = 8'hAA;
  localparam int       GAP = 4;
  localparam int       RW  = 8;

  typedef struct packed { logic b; logic first; logic last; } ent_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic abort = 1'b0;
  logic next = 1'b0;
  always #5 clock = ~clock;

  framed_packet_serializer_if #(.PACKET_SIZE(N), .REPEAT_WIDTH(RW)) if0 ();
  framed_packet_serializer_if #(.PACKET_SIZE(N), .REPEAT_WIDTH(RW)) if1 ();

  logic bo0, bv0, fs0, fd0, bz0;
  logic bo1, bv1, fs1, fd1, bz1;

  framed_packet_serializer #(.PACKET_SIZE(N), .PREAMBLE_WIDTH(PW), .PREAMBLE(PRE),
    .GAP_BITS(GAP), .LSB_FIRST(0), .REPEAT_WIDTH(RW)) dut0 (
    .clock(clock), .reset_n(reset_n), .ld(if0), .abort(abort), .next(next),
    .bit_out(bo0), .bit_valid(bv0), .frame_start(fs0), .frame_done(fd0), .busy(bz0));

  framed_packet_serializer #(.PACKET_SIZE(N), .PREAMBLE_WIDTH(PW), .PREAMBLE(PRE),
    .GAP_BITS(GAP), .LSB_FIRST(1), .REPEAT_WIDTH(RW)) dut1 (
    .clock(clock), .reset_n(reset_n), .ld(if1), .abort(abort), .next(next),
    .bit_out(bo1), .bit_valid(bv1), .frame_start(fs1), .frame_done(fd1), .busy(bz1));

  int checks = 0;
  int failures = 0;

  // Reference model: queue of the bits still to be consumed, per DUT.
  ent_t q0[$];
  ent_t q1[$];
  bit   head_new = 0;
  bit   exp_fd = 0;
  int   popped = 0;
  int   fs_seen = 0, fd_seen = 0, bits_seen = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q0.delete(); q1.delete();
      head_new = 0; exp_fd = 0;
    end else begin
      head_new = 0; exp_fd = 0;
      if (abort) begin
        q0.delete(); q1.delete();
      end else if (q0.size() == 0) begin
        if (if0.load_valid) begin
          logic [N-1:0]  p;
          logic [RW-1:0] r;
          p = if0.load_packet;
          r = if0.load_repeat;
          for (int f = 0; f <= int'(r); f++) begin
            for (int i = PW-1; i >= 0; i--) begin
              q0.push_back('{PRE[i], i == PW-1, 1'b0});
              q1.push_back('{PRE[i], i == PW-1, 1'b0});
            end
            for (int k = 0; k < N; k++) begin
              q0.push_back('{p[N-1-k], 1'b0, k == N-1});
              q1.push_back('{p[k],     1'b0, k == N-1});
            end
            if (f < int'(r))
              for (int g = 0; g < GAP; g++) begin
                q0.push_back('{1'b0, 1'b0, 1'b0});
                q1.push_back('{1'b0, 1'b0, 1'b0});
              end
          end
          head_new = 1;
          popped = 0;
        end
      end else if (next) begin
        exp_fd = q0[0].last;
        void'(q0.pop_front());
        void'(q1.pop_front());
        popped++;
        head_new = (q0.size() != 0);
      end
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Monitor: compare both DUTs against the model head away from the active edge.
  always @(negedge clock) begin
    logic ebv, e0, e1, efs, erdy;
    ebv  = (q0.size() != 0);
    e0   = ebv ? q0[0].b : 1'b0;
    e1   = ebv ? q1[0].b : 1'b0;
    efs  = ebv && head_new && q0[0].first;
    erdy = !ebv && !abort;
    chk("bit_out0", bo0, e0);      chk("bit_out1", bo1, e1);
    chk("bit_valid0", bv0, ebv);   chk("bit_valid1", bv1, ebv);
    chk("busy0", bz0, ebv);        chk("busy1", bz1, ebv);
    chk("frame_start0", fs0, efs); chk("frame_start1", fs1, efs);
    chk("frame_done0", fd0, exp_fd); chk("frame_done1", fd1, exp_fd);
    chk("load_ready0", if0.load_ready, erdy);
    chk("load_ready1", if1.load_ready, erdy);
    if (fs0) fs_seen++;
    if (fd0) fd_seen++;
    if (bv0 && next) bits_seen++;
  end

  task automatic do_load(input logic [N-1:0] p, input logic [RW-1:0] r);
    int n = 0;
    while (!if0.load_ready) begin
      @(posedge clock); #1;
      n++;
      if (n > 1000) begin chk_int("load_ready_timeout", 0, 1); return; end
    end
    if0.load_packet = p; if1.load_packet = p;
    if0.load_repeat = r; if1.load_repeat = r;
    if0.load_valid = 1'b1; if1.load_valid = 1'b1;
    @(posedge clock); #1;
    if0.load_valid = 1'b0; if1.load_valid = 1'b0;
  endtask

  // Strobe `next` until the model drains or stop_pop bits were consumed.
  task automatic stream(input int period, input int stop_pop, input bit rnd);
    for (int i = 0; i < 6000; i++) begin
      if (q0.size() == 0 || popped >= stop_pop) begin next = 1'b0; return; end
      next = rnd ? ($urandom_range(0, 1) == 1) : ((i % period) == period - 1);
      @(posedge clock); #1;
    end
    next = 1'b0;
    chk_int("stream_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    if0.load_valid = 0; if1.load_valid = 0;
    if0.load_packet = '0; if1.load_packet = '0;
    if0.load_repeat = '0; if1.load_repeat = '0;
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // MSB (dut0) and LSB (dut1) orderings, single frame, next every 4 cycles
    do_load(16'hA5C3, 0);
    stream(4, 1000, 0);
    idle(3);

    // three frames with gaps
    fs_seen = 0; fd_seen = 0; bits_seen = 0;
    do_load(16'hA5C3, 2);
    stream(4, 1000, 0);
    idle(3);
    chk_int("rep_frame_starts", fs_seen, 3);
    chk_int("rep_frame_dones", fd_seen, 3);
    chk_int("rep_bits_consumed", bits_seen, 80);

    // abort the cycle after payload bit 5 is consumed
    fd_seen = 0;
    do_load(16'hA5C3, 0);
    stream(4, PW + 6, 0);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    idle(3);
    chk_int("abort_no_frame_done", fd_seen, 0);
    do_load(16'h0001, 0);
    stream(3, 1000, 0);
    idle(3);

    // load attempt while busy, then async reset mid-payload
    do_load(16'h1234, 1);
    stream(2, PW + 5, 0);
    if0.load_packet = 16'hFFFF; if1.load_packet = 16'hFFFF;
    if0.load_valid = 1'b1; if1.load_valid = 1'b1;
    stream(2, PW + 9, 0);
    #2 reset_n = 1'b0;
    idle(2);
    if0.load_valid = 1'b0; if1.load_valid = 1'b0;
    idle(1);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin next = i[0]; idle(1); end
    next = 1'b0;

    // next held continuously, including the accept cycle
    next = 1'b1;
    do_load(16'h5A3C, 0);
    stream(1, 1000, 0);
    idle(3);

    // randomized packets, repeat counts and strobe timing
    for (int t = 0; t < 6; t++) begin
      do_load(N'($urandom), RW'($urandom_range(0, 2)));
      stream(1, 1000, 1);
      idle(2);
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
